// File: rtl/baby_kyber_pkg.sv
// Shared constants, coefficient/polynomial types, FSM state encoding and the
// canonical mod-Q reduction for the Baby Kyber encryption engine.
package baby_kyber_pkg;

  localparam int Q   = 17;
  localparam int N   = 4;
  localparam int K   = 2;
  localparam int ETA = 2;

  typedef logic signed [31:0] coef_t;
  typedef coef_t [N-1:0]      poly_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIN,
    DONE
  } state_t;

  // Maps any signed value into [0,Q-1]; the extra +Q folds negative remainders.
  function automatic coef_t mod_q(input coef_t x);
    coef_t r;
    r = x % coef_t'(Q);
    r = r + coef_t'(Q);
    return r % coef_t'(Q);
  endfunction

endpackage

// File: rtl/poly_mul_negacyclic.sv
// Combinational product of two N-coefficient polynomials mod (x^N+1),
// every output coefficient reduced into [0,Q-1].
module poly_mul_negacyclic
  import baby_kyber_pkg::*;
(
  input  poly_t i_a,
  input  poly_t i_b,
  output poly_t o_c
);

  // Operands are reduced first so the partial products stay far from overflow.
  function automatic poly_t negacyclic_mul(input poly_t a, input poly_t b);
    coef_t ar  [N];
    coef_t br  [N];
    coef_t acc [N];
    poly_t c;
    for (int i = 0; i < N; i++) begin
      ar[i]  = mod_q(a[i]);
      br[i]  = mod_q(b[i]);
      acc[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i + j < N) acc[i+j]   = acc[i+j]   + ar[i] * br[j];
        else           acc[i+j-N] = acc[i+j-N] - ar[i] * br[j];
      end
    end
    for (int i = 0; i < N; i++) c[i] = mod_q(acc[i]);
    return c;
  endfunction

  always_comb begin
    o_c = negacyclic_mul(i_a, i_b);
  end

endmodule

// File: rtl/baby_kyber_encrypt.sv
// Baby Kyber encryption: u = A^T*r + e1, v = t^T*r + e2 + 9*m over one shared
// negacyclic multiplier. Define BK_ENC_ERR_EN to enable the noise-range err flag.
module baby_kyber_encrypt
  import baby_kyber_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       start,
  input  logic [3:0]                 msg,
  input  poly_t [K-1:0][K-1:0]       pk_a,
  input  poly_t [K-1:0]              pk_t,
  input  poly_t [K-1:0]              r_vec,
  input  poly_t [K-1:0]              e1_vec,
  input  poly_t                      e2_poly,
  output poly_t [1:0][1:0]           ciphertext,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  state_t                r_state;
  logic [2:0]            r_idx;
  logic                  r_busy;
  logic                  r_done;
  poly_t [1:0][1:0]      r_ct;
  poly_t                 r_acc_u0;
  poly_t                 r_acc_u1;
  poly_t                 r_acc_v;

  poly_t [K-1:0][K-1:0]  r_a;
  poly_t [K-1:0]         r_t;
  poly_t [K-1:0]         r_r;
  poly_t [K-1:0]         r_e1;
  poly_t                 r_e2;
  logic [3:0]            r_msg;

  logic                  w_accept;
  poly_t                 w_op_a;
  poly_t                 w_op_r;
  poly_t                 w_prod;

  assign w_accept = enable && (r_state == IDLE) && start;

  // Operand snapshot; only the accepting edge matters, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= pk_a;
      r_t   <= pk_t;
      r_r   <= r_vec;
      r_e1  <= e1_vec;
      r_e2  <= e2_poly;
      r_msg <= msg;
    end
  end

  // Odd indices always pair with r1, even with r0.
  always_comb begin
    w_op_r = r_r[r_idx[0]];
    case (r_idx)
      3'd0:    w_op_a = r_a[0][0];
      3'd1:    w_op_a = r_a[1][0];
      3'd2:    w_op_a = r_a[0][1];
      3'd3:    w_op_a = r_a[1][1];
      3'd4:    w_op_a = r_t[0];
      default: w_op_a = r_t[1];
    endcase
  end

  poly_mul_negacyclic u_mul (
    .i_a (w_op_a),
    .i_b (w_op_r),
    .o_c (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ct     <= '0;
      r_acc_u0 <= '0;
      r_acc_u1 <= '0;
      r_acc_v  <= '0;
    end else if (enable) begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy   <= 1'b1;
            r_idx    <= '0;
            r_acc_u0 <= '0;
            r_acc_u1 <= '0;
            r_acc_v  <= '0;
            r_state  <= MUL;
          end
        end
        MUL: begin
          for (int i = 0; i < N; i++) begin
            case (r_idx)
              3'd0, 3'd1: r_acc_u0[i] <= r_acc_u0[i] + w_prod[i];
              3'd2, 3'd3: r_acc_u1[i] <= r_acc_u1[i] + w_prod[i];
              default:    r_acc_v[i]  <= r_acc_v[i]  + w_prod[i];
            endcase
          end
          if (r_idx == 3'd5) begin
            r_idx   <= '0;
            r_state <= FIN;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        FIN: begin
          for (int i = 0; i < N; i++) begin
            r_ct[0][0][i] <= mod_q(r_acc_u0[i] + r_e1[0][i]);
            r_ct[0][1][i] <= mod_q(r_acc_u1[i] + r_e1[1][i]);
            r_ct[1][0][i] <= mod_q(r_acc_v[i] + r_e2[i] + coef_t'(9 * r_msg[i]));
            r_ct[1][1][i] <= '0;
          end
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BK_ENC_ERR_EN
  logic r_err;
  logic w_noise_bad;

  function automatic logic out_of_eta(input coef_t x);
    return (x > coef_t'(ETA)) || (x < -coef_t'(ETA));
  endfunction

  always_comb begin
    w_noise_bad = 1'b0;
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < N; i++) begin
        if (out_of_eta(r_vec[k][i]) || out_of_eta(e1_vec[k][i])) w_noise_bad = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (out_of_eta(e2_poly[i])) w_noise_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_err <= 1'b0;
    else if (w_accept) r_err <= w_noise_bad;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign ciphertext = r_ct;
  assign busy       = r_busy;
  // A stalled DONE cycle must not look like a completed pulse.
  assign done       = r_done & enable;

endmodule
